// File: rtl/vga_pkg.sv
// Shared timing defaults, widths and colour type for the VGA overlay controller.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned COLOR_W = 24;
    localparam int unsigned CNT_W   = 11;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned ADDR_W  = 19;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } color_t;

    function automatic int unsigned total_count(input int unsigned active, input int unsigned fp,
                                                input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with decoded active, sync and frame-end strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_active_c,
    output logic             o_hs_c,
    output logic             o_vs_c,
    output logic             o_frame_end_c
);

    localparam int unsigned H_TOTAL  = total_count(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = total_count(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_active_c    = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
    assign o_hs_c        = ((r_h_cnt >= CNT_W'(HS_START)) && (r_h_cnt < CNT_W'(HS_END))) ? SYNC_POL : ~SYNC_POL;
    assign o_vs_c        = ((r_v_cnt >= CNT_W'(VS_START)) && (r_v_cnt < CNT_W'(VS_END))) ? SYNC_POL : ~SYNC_POL;
    assign o_frame_end_c = w_h_last && w_v_last;

endmodule

// File: rtl/vga_overlay_ctrl.sv
// VGA raster with background addressing and N_OBJ prioritised rectangular overlays;
// overlay state is shadowed at frame end and a per-frame collision mask is reported.
module vga_overlay_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned N_OBJ    = 4,
    parameter int unsigned OBJ_W    = 16,
    parameter int unsigned OBJ_H    = 16,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic                     iVGA_CLK,
    input  logic                     iRST_n,
    input  logic [POS_W*N_OBJ-1:0]   iObj_x,
    input  logic [POS_W*N_OBJ-1:0]   iObj_y,
    input  logic [N_OBJ-1:0]         iObj_en,
    input  logic [COLOR_W*N_OBJ-1:0] iObj_color,
    input  logic [COLOR_W-1:0]       iBg_data,
    output logic [ADDR_W-1:0]        oADDR,
    output logic                     oHS,
    output logic                     oVS,
    output logic                     oBLANK_n,
    output logic [7:0]               b_data,
    output logic [7:0]               g_data,
    output logic [7:0]               r_data,
    output logic                     oFrame_start,
    output logic [N_OBJ-1:0]         oCollide
);

    logic [CNT_W-1:0]         w_h_cnt;
    logic [CNT_W-1:0]         w_v_cnt;
    logic                     w_active_c;
    logic                     w_hs_c;
    logic                     w_vs_c;
    logic                     w_frame_end_c;

    logic [ADDR_W-1:0]        r_addr;
    logic [POS_W*N_OBJ-1:0]   r_sh_x;
    logic [POS_W*N_OBJ-1:0]   r_sh_y;
    logic [N_OBJ-1:0]         r_sh_en;
    logic [COLOR_W*N_OBJ-1:0] r_sh_color;

    logic [CNT_W-1:0]         r_s1_x;
    logic [CNT_W-1:0]         r_s1_y;
    logic                     r_s1_active;
    logic                     r_s1_hs;
    logic                     r_s1_vs;

    logic [N_OBJ-1:0]         w_hit;
    logic                     w_found;
    logic                     w_multi;
    color_t                   w_pix;

    logic [N_OBJ-1:0]         r_acc;
    logic [N_OBJ-1:0]         r_collide;
    logic                     r_hs;
    logic                     r_vs;
    logic                     r_blank_n;
    logic                     r_frame_start;
    color_t                   r_color;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .i_clk         (iVGA_CLK),
        .i_rst_n       (iRST_n),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_active_c    (w_active_c),
        .o_hs_c        (w_hs_c),
        .o_vs_c        (w_vs_c),
        .o_frame_end_c (w_frame_end_c)
    );

    // Stage 0: background address and frame-boundary shadow capture.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_addr     <= '0;
            r_sh_x     <= '0;
            r_sh_y     <= '0;
            r_sh_en    <= '0;
            r_sh_color <= '0;
        end else if (w_frame_end_c) begin
            r_addr     <= '0;
            r_sh_x     <= iObj_x;
            r_sh_y     <= iObj_y;
            r_sh_en    <= iObj_en;
            r_sh_color <= iObj_color;
        end else if (w_active_c) begin
            r_addr     <= r_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_active <= 1'b0;
            r_s1_hs     <= ~SYNC_POL;
            r_s1_vs     <= ~SYNC_POL;
        end else begin
            r_s1_x      <= w_h_cnt;
            r_s1_y      <= w_v_cnt;
            r_s1_active <= w_active_c;
            r_s1_hs     <= w_hs_c;
            r_s1_vs     <= w_vs_c;
        end
    end

    // Stage 1: 11-bit edge sums so overlays near the right/bottom clip instead of wrapping.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < int'(N_OBJ); k++) begin
            w_hit[k] = r_sh_en[k]
                && (r_s1_x >= CNT_W'(r_sh_x[POS_W*k +: POS_W]))
                && (r_s1_x <  CNT_W'(r_sh_x[POS_W*k +: POS_W]) + CNT_W'(OBJ_W))
                && (r_s1_y >= CNT_W'(r_sh_y[POS_W*k +: POS_W]))
                && (r_s1_y <  CNT_W'(r_sh_y[POS_W*k +: POS_W]) + CNT_W'(OBJ_H));
        end
    end

    always_comb begin
        w_pix   = color_t'(iBg_data);
        w_found = 1'b0;
        for (int k = 0; k < int'(N_OBJ); k++) begin
            if (w_hit[k] && !w_found) begin
                w_pix   = color_t'(r_sh_color[COLOR_W*k +: COLOR_W]);
                w_found = 1'b1;
            end
        end
    end

    assign w_multi = ($countones(w_hit) > 1);

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_acc     <= '0;
            r_collide <= '0;
        end else if (w_frame_end_c) begin
            r_collide <= r_acc;
            r_acc     <= '0;
        end else if (r_s1_active && w_multi) begin
            r_acc     <= r_acc | w_hit;
        end
    end

    // Stage 2: registered colour and syncs, aligned two cycles behind the counters.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_blank_n     <= 1'b0;
            r_color       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_hs          <= r_s1_hs;
            r_vs          <= r_s1_vs;
            r_blank_n     <= r_s1_active;
            r_color       <= r_s1_active ? w_pix : '0;
            r_frame_start <= w_frame_end_c;
        end
    end

    assign oADDR        = r_addr;
    assign oHS          = r_hs;
    assign oVS          = r_vs;
    assign oBLANK_n     = r_blank_n;
    assign b_data       = r_color.b;
    assign g_data       = r_color.g;
    assign r_data       = r_color.r;
    assign oFrame_start = r_frame_start;
    assign oCollide     = r_collide;

endmodule

// File: tb/tb_vga_overlay_ctrl.sv
// Randomised self-checking bench for vga_overlay_ctrl on a reduced 8x4 raster,
// compared against a pixel-index reference model with per-frame overlay snapshots.
module tb_vga_overlay_ctrl;

    localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int NO = 4, OW = 5, OH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [10*NO-1:0]  obj_x;
    logic [10*NO-1:0]  obj_y;
    logic [NO-1:0]     obj_en;
    logic [24*NO-1:0]  obj_col;
    logic [23:0]       bg;
    logic [18:0]       addr;
    logic              hs, vs, blank_n, fs;
    logic [7:0]        b, g, r;
    logic [NO-1:0]     coll;

    vga_overlay_ctrl #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .N_OBJ (NO), .OBJ_W (OW), .OBJ_H (OH), .SYNC_POL (1'b0)
    ) dut (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .iObj_x       (obj_x),
        .iObj_y       (obj_y),
        .iObj_en      (obj_en),
        .iObj_color   (obj_col),
        .iBg_data     (bg),
        .oADDR        (addr),
        .oHS          (hs),
        .oVS          (vs),
        .oBLANK_n     (blank_n),
        .b_data       (b),
        .g_data       (g),
        .r_data       (r),
        .oFrame_start (fs),
        .oCollide     (coll)
    );

    always #5 clk = ~clk;

    logic [23:0]      mem  [0:1023];
    logic [10*NO-1:0] cx   [0:63];
    logic [10*NO-1:0] cy   [0:63];
    logic [NO-1:0]    cen  [0:63];
    logic [24*NO-1:0] ccol [0:63];

    int checks = 0;
    int errors = 0;
    int k      = 0;
    bit in_rst = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic bit hit(int f, int j, int x, int y);
        int ox, oy;
        ox = int'(cx[f][10*j +: 10]);
        oy = int'(cy[f][10*j +: 10]);
        return cen[f][j] && (x >= ox) && (x < ox + OW) && (y >= oy) && (y < oy + OH);
    endfunction

    function automatic logic [23:0] exp_pix(int f, int x, int y);
        for (int j = 0; j < NO; j++)
            if (hit(f, j, x, y)) return ccol[f][24*j +: 24];
        return mem[y*HA + x];
    endfunction

    function automatic logic [NO-1:0] exp_coll(int f);
        logic [NO-1:0] m, h;
        m = '0;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) begin
                h = '0;
                for (int j = 0; j < NO; j++) h[j] = hit(f, j, x, y);
                if ($countones(h) >= 2) m = m | h;
            end
        return m;
    endfunction

    task automatic check_outputs();
        int c, p, x, y, f, p0, x0, y0, fk;
        logic [23:0] pix;
        logic        eb, ehs, evs;
        logic [18:0] ea;
        logic [NO-1:0] ec;
        if (in_rst) begin
            chk("rst_blank", 32'(blank_n), 32'(0));
            chk("rst_rgb", 32'({b, g, r}), 32'(0));
            chk("rst_hs", 32'(hs), 32'(1));
            chk("rst_vs", 32'(vs), 32'(1));
            chk("rst_collide", 32'(coll), 32'(0));
            chk("rst_fstart", 32'(fs), 32'(0));
            chk("rst_addr", 32'(addr), 32'(0));
            return;
        end
        c = k - 2;
        if (c < 0) begin
            eb = 1'b0; ehs = 1'b1; evs = 1'b1; pix = '0;
        end else begin
            p = c % FT; x = p % HT; y = p / HT; f = c / FT;
            eb  = (x < HA) && (y < VA);
            ehs = !((x >= HA + HFP) && (x < HA + HFP + HSY));
            evs = !((y >= VA + VFP) && (y < VA + VFP + VSY));
            pix = eb ? exp_pix(f, x, y) : 24'h0;
        end
        p0 = k % FT; x0 = p0 % HT; y0 = p0 / HT; fk = k / FT;
        ea = (y0 >= VA) ? 19'(HA*VA) : 19'(y0*HA + ((x0 < HA) ? x0 : HA));
        ec = (fk >= 1) ? exp_coll(fk - 1) : '0;
        chk("blank_n", 32'(blank_n), 32'(eb));
        chk("hs", 32'(hs), 32'(ehs));
        chk("vs", 32'(vs), 32'(evs));
        chk("rgb", 32'({b, g, r}), 32'(pix));
        chk("addr", 32'(addr), 32'(ea));
        chk("frame_start", 32'(fs), 32'((k > 0) && (p0 == 0)));
        chk("collide", 32'(coll), 32'(ec));
    endtask

    task automatic step();
        logic [18:0] a;
        int nf;
        a = addr;
        if (!in_rst && (k % FT) == FT - 1) begin
            nf = k / FT + 1;
            if (nf < 64) begin
                cx[nf] = obj_x; cy[nf] = obj_y; cen[nf] = obj_en; ccol[nf] = obj_col;
            end
        end
        @(posedge clk);
        #1;
        bg = mem[a[9:0]];
        if (!in_rst) k++;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic release_rst();
        rst_n  = 1'b1;
        in_rst = 1'b0;
        k      = 0;
        cx[0] = '0; cy[0] = '0; cen[0] = '0; ccol[0] = '0;
        check_outputs();
    endtask

    task automatic set_obj(input int j, input int x, input int y, input bit en, input logic [23:0] col);
        obj_x[10*j +: 10]   = 10'(x);
        obj_y[10*j +: 10]   = 10'(y);
        obj_en[j]           = en;
        obj_col[24*j +: 24] = col;
    endtask

    task automatic rand_obj(input int j);
        int x;
        x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 9));
        set_obj(j, x, int'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0), 24'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 24'($urandom);
        obj_x = '0; obj_y = '0; obj_en = '0; obj_col = '0; bg = '0;
        rst_n = 1'b0;
        in_rst = 1'b1;
        run(5);
        release_rst();

        // Overlay enabled mid-frame only shows from the next frame on.
        run(40);
        set_obj(0, 2, 1, 1'b1, 24'hC0FFEE);
        run(2*FT);

        // Overlapping overlays: lower index wins, collision reported next frame.
        set_obj(0, 3, 1, 1'b1, 24'h0000FF);
        set_obj(1, 4, 2, 1'b1, 24'h00FF00);
        run(2*FT);
        obj_en[1] = 1'b0;
        run(2*FT);

        // Right-edge clipping without wrap into the next line.
        obj_en = '0;
        set_obj(2, HA - 4, 0, 1'b1, 24'h123456);
        run(2*FT);

        // Random overlay updates at arbitrary cycles, including frame-end cycles.
        repeat (12*FT) begin
            if ($urandom_range(0, 15) == 0) rand_obj(int'($urandom_range(0, NO - 1)));
            step();
        end

        // Single-cycle reset mid-line restarts the raster with a clean collision report.
        run(FT/2 + 3);
        rst_n  = 1'b0;
        in_rst = 1'b1;
        step();
        release_rst();
        run(3*FT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
